// File: rtl/addrdec2.sv
// System address decoder for the low 64K map: memory, I/O and simif selects,
// per-region wait-state handshake and sticky unmapped-access error capture.
module addrdec2 #(
  parameter int MEM_ADDR_SIZE = 32,
  parameter int PAGE_BITS     = 4,
  parameter int MEM_PAGES     = 4,
  parameter int IO_FIRST_PAGE = 12,
  parameter int IO_CH         = 4,
  parameter int WAIT_BITS     = 4,
  parameter int MEM_WAIT      = 1,
  parameter int IO_WAIT       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MEM_ADDR_SIZE-1:0] addr,
  input  logic                     req,
  output logic                     cs_mem,
  output logic [IO_CH-1:0]         cs_io,
  output logic                     cs_simif,
  output logic                     ready,
  output logic                     bus_err,
  output logic                     err_flag,
  output logic [MEM_ADDR_SIZE-1:0] err_addr,
  output logic [7:0]               err_cnt,
  input  logic                     err_clr
);

  localparam logic [WAIT_BITS-1:0] MEM_W = WAIT_BITS'(MEM_WAIT);
  localparam logic [WAIT_BITS-1:0] IO_W  = WAIT_BITS'(IO_WAIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [WAIT_BITS-1:0]     wcnt_q, wcnt_d;
  logic                     err_flag_q, err_flag_d;
  logic [MEM_ADDR_SIZE-1:0] err_addr_q, err_addr_d;
  logic [7:0]               err_cnt_q, err_cnt_d;

  logic                     in64, simhit, unmapped;
  logic [PAGE_BITS-1:0]     page;
  logic [WAIT_BITS-1:0]     nwait;

  always_comb begin
    in64     = (addr[MEM_ADDR_SIZE-1:16] == '0);
    page     = addr[15:16-PAGE_BITS];
    simhit   = in64 & (addr[15:0] == 16'hffff);
    cs_simif = reset & req & simhit;
    cs_mem   = reset & req & in64 & (int'(page) < MEM_PAGES) & ~simhit;
    cs_io    = '0;
    for (int unsigned i = 0; i < IO_CH; i++)
      cs_io[i] = reset & req & in64 & (int'(page) == IO_FIRST_PAGE + int'(i)) & ~simhit;
    unmapped = reset & req & ~cs_mem & ~cs_simif & ~(|cs_io);
    nwait    = cs_mem ? MEM_W : ((|cs_io) ? IO_W : '0);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ready   = 1'b0;
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (nwait == '0) begin
              ready = 1'b1;
            end else begin
              wcnt_d  = nwait - WAIT_BITS'(1);
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_d = ST_IDLE;
          end else if (wcnt_q == '0) begin
            ready   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q - WAIT_BITS'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus_err = ready & unmapped & (state_q == ST_IDLE);

  // Clear is applied first so that a same-cycle error restarts the capture.
  always_comb begin
    err_flag_d = err_clr ? 1'b0 : err_flag_q;
    err_cnt_d  = err_clr ? '0   : err_cnt_q;
    err_addr_d = err_addr_q;
    if (bus_err) begin
      if (!err_flag_d) err_addr_d = addr;
      err_flag_d = 1'b1;
      if (err_cnt_d != 8'hff) err_cnt_d = err_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_addrdec2.sv
// Bench for addrdec2: two instances (memory wait 1 and 3) driven in parallel,
// checked every cycle against an address-map / latency reference model.
module tb_addrdec2;

  localparam int AW = 32;
  localparam int IO_WAIT_V = 0;
  localparam int W_MEM [2] = '{1, 3};

  logic          clk = 1'b0;
  logic          reset, req, err_clr;
  logic [AW-1:0] addr;

  logic          cs_mem_o [2];
  logic [3:0]    cs_io_o [2];
  logic          cs_simif_o [2];
  logic          ready_o [2];
  logic          bus_err_o [2];
  logic          err_flag_o [2];
  logic [AW-1:0] err_addr_o [2];
  logic [7:0]    err_cnt_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  int          m_elapsed [2];
  logic        m_flag [2];
  logic [31:0] m_addr [2];
  int          m_cnt [2];

  always #5 clk = ~clk;

  addrdec2 u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .req(req),
    .cs_mem(cs_mem_o[0]), .cs_io(cs_io_o[0]), .cs_simif(cs_simif_o[0]),
    .ready(ready_o[0]), .bus_err(bus_err_o[0]), .err_flag(err_flag_o[0]),
    .err_addr(err_addr_o[0]), .err_cnt(err_cnt_o[0]), .err_clr(err_clr)
  );

  addrdec2 #(.MEM_WAIT(3)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .req(req),
    .cs_mem(cs_mem_o[1]), .cs_io(cs_io_o[1]), .cs_simif(cs_simif_o[1]),
    .ready(ready_o[1]), .bus_err(bus_err_o[1]), .err_flag(err_flag_o[1]),
    .err_addr(err_addr_o[1]), .err_cnt(err_cnt_o[1]), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind: 0 unmapped, 1 memory, 2 I/O channel ch, 3 simif
  function automatic void classify(input logic [31:0] a, output int kind, output int ch);
    int pg;
    kind = 0;
    ch   = 0;
    if (a < 32'h1_0000) begin
      pg = int'(a / 4096);
      if (a == 32'hffff)  kind = 3;
      else if (pg < 4)    kind = 1;
      else if (pg >= 12) begin
        kind = 2;
        ch   = pg - 12;
      end
    end
  endfunction

  function automatic int wait_for(input int k, input int kind);
    if (kind == 1) return W_MEM[k];
    if (kind == 2) return IO_WAIT_V;
    return 0;
  endfunction

  task automatic model_check();
    int kind, ch, nw;
    logic act, exp_ready;
    classify(addr, kind, ch);
    act = reset && req;
    for (int k = 0; k < 2; k++) begin
      nw = wait_for(k, kind);
      exp_ready = act && (m_elapsed[k] == nw);
      check($sformatf("u%0d.cs_mem", k),   64'(cs_mem_o[k]),   64'(act && kind == 1));
      check($sformatf("u%0d.cs_simif", k), 64'(cs_simif_o[k]), 64'(act && kind == 3));
      check($sformatf("u%0d.cs_io", k),    64'(cs_io_o[k]),
            (act && kind == 2) ? 64'(1) << ch : 64'(0));
      check($sformatf("u%0d.ready", k),    64'(ready_o[k]),    64'(exp_ready));
      check($sformatf("u%0d.bus_err", k),  64'(bus_err_o[k]),  64'(exp_ready && kind == 0));
      check($sformatf("u%0d.err_flag", k), 64'(err_flag_o[k]), 64'(m_flag[k]));
      check($sformatf("u%0d.err_addr", k), 64'(err_addr_o[k]), 64'(m_addr[k]));
      check($sformatf("u%0d.err_cnt", k),  64'(err_cnt_o[k]),  64'(m_cnt[k]));
    end
  endtask

  task automatic model_update();
    int kind, ch, nw;
    logic done, err;
    classify(addr, kind, ch);
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_elapsed[k] = 0;
        m_flag[k] = 1'b0;
        m_addr[k] = 32'h0;
        m_cnt[k]  = 0;
      end else begin
        nw   = wait_for(k, kind);
        done = req && (m_elapsed[k] == nw);
        err  = done && kind == 0;
        if (!req || done) m_elapsed[k] = 0;
        else              m_elapsed[k] = m_elapsed[k] + 1;
        if (err) begin
          if (err_clr || !m_flag[k]) m_addr[k] = addr;
          m_cnt[k]  = err_clr ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
          m_flag[k] = 1'b1;
        end else if (err_clr) begin
          m_flag[k] = 1'b0;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle1();
    req = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 6)
      0: return $urandom % 16384;
      1: return ((12 + $urandom % 4) << 12) | ($urandom % 4096);
      2: return 32'h0000_ffff;
      3: return ((4 + $urandom % 8) << 12) | ($urandom % 4096);
      4: return $urandom;
      default: return ((1 + $urandom % 4) << 16) | ($urandom % 65536);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_elapsed[k] = 0; m_flag[k] = 1'b0; m_addr[k] = 32'h0; m_cnt[k] = 0;
    end
    reset = 1'b0; req = 1'b1; addr = 32'h0000_2000; err_clr = 1'b0;
    #1;
    check("rst.cs_mem", 64'(cs_mem_o[0]), 64'(0));
    check("rst.ready",  64'(ready_o[0]),  64'(0));
    tick(); tick();
    check("rst.err_cnt",  64'(err_cnt_o[0]),  64'(0));
    check("rst.err_addr", 64'(err_addr_o[1]), 64'(0));

    // memory access with one wait cycle (u0) and three (u1)
    reset = 1'b1;
    #1;
    check("mem.cs_mem", 64'(cs_mem_o[0]), 64'(1));
    check("mem.cs_io",  64'(cs_io_o[0]),  64'(0));
    check("mem.ready0", 64'(ready_o[0]),  64'(0));
    tick();
    check("mem.ready1", 64'(ready_o[0]),  64'(1));
    tick();
    check("mem3.c2", 64'(ready_o[1]), 64'(0));
    tick();
    check("mem3.c3", 64'(ready_o[1]), 64'(1));
    tick();
    idle1();

    // zero-wait I/O then simif, back to back
    req = 1'b1; addr = 32'h0000_d004;
    #1;
    check("io.cs_io", 64'(cs_io_o[0]), 64'h2);
    check("io.ready", 64'(ready_o[0]), 64'(1));
    tick();
    addr = 32'h0000_ffff;
    #1;
    check("sim.cs_simif", 64'(cs_simif_o[0]), 64'(1));
    check("sim.cs_io",    64'(cs_io_o[0]),    64'(0));
    check("sim.ready",    64'(ready_o[0]),    64'(1));
    tick();
    idle1();

    // unmapped accesses
    req = 1'b1; addr = 32'h0001_0000;
    #1;
    check("um.bus_err", 64'(bus_err_o[0]), 64'(1));
    check("um.ready",   64'(ready_o[0]),   64'(1));
    check("um.cs_mem",  64'(cs_mem_o[0]),  64'(0));
    tick();
    check("um.err_flag", 64'(err_flag_o[0]), 64'(1));
    check("um.err_addr", 64'(err_addr_o[0]), 64'h1_0000);
    check("um.err_cnt",  64'(err_cnt_o[0]),  64'(1));
    addr = 32'h0000_5000;
    tick();
    check("um2.err_cnt",  64'(err_cnt_o[0]),  64'(2));
    check("um2.err_addr", 64'(err_addr_o[0]), 64'h1_0000);
    idle1();

    // saturation, then clear colliding with a new error
    req = 1'b1; addr = 32'h0002_0000;
    for (int i = 0; i < 300; i++) tick();
    check("sat.err_cnt", 64'(err_cnt_o[0]), 64'd255);
    err_clr = 1'b1; addr = 32'h0000_8000;
    tick();
    err_clr = 1'b0;
    check("clr.err_flag", 64'(err_flag_o[0]), 64'(1));
    check("clr.err_cnt",  64'(err_cnt_o[0]),  64'(1));
    check("clr.err_addr", 64'(err_addr_o[0]), 64'h8000);
    idle1();

    // aborted wait then full re-request on the 3-wait instance
    req = 1'b1; addr = 32'h0000_2000;
    tick(); tick();
    req = 1'b0;
    #1;
    check("abort.ready", 64'(ready_o[1]), 64'(0));
    tick();
    req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rereq.c%0d", c), 64'(ready_o[1]), 64'(c == 3));
      tick();
    end
    idle1();

    // reset in the middle of a wait
    req = 1'b1; addr = 32'h0000_2000;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rstw.cs_mem", 64'(cs_mem_o[1]), 64'(0));
    check("rstw.ready",  64'(ready_o[1]),  64'(0));
    tick();
    check("rstw.err_flag", 64'(err_flag_o[1]), 64'(0));
    check("rstw.err_cnt",  64'(err_cnt_o[1]),  64'(0));
    check("rstw.err_addr", 64'(err_addr_o[1]), 64'(0));
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("postrst.c%0d", c), 64'(ready_o[1]), 64'(c == 3));
      tick();
    end
    idle1();

    // randomized traffic; address only moves when no access is in flight
    for (int i = 0; i < 3000; i++) begin
      if (m_elapsed[0] == 0 && m_elapsed[1] == 0) begin
        addr = rand_addr();
        req  = ($urandom % 4) != 0;
      end else if (($urandom % 10) == 0) begin
        req = 1'b0;
      end
      err_clr = ($urandom % 16) == 0;
      reset   = ($urandom % 64) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addrdec2.md
Name: addrdec2

Overview:
- Parametrised next-generation system address decoder for the low 64K I/O and memory map.
- Decodes a bus address into one memory select, IO_CH I/O chip selects and the simulator-interface select.
- Adds a per-region wait-state handshake, so the bus sees `ready` after a fixed number of cycles.
- Adds sticky unmapped-access error capture: flag, address and count.
- Sits between the CPU bus master and the memory, peripheral and simif slaves.

Parameters:
- MEM_ADDR_SIZE, 32, bus address width; must be at least 17.
- PAGE_BITS, 4, number of addr[15:...] bits that select a page; page size is 2^(16-PAGE_BITS) bytes.
- MEM_PAGES, 4, pages 0..MEM_PAGES-1 are memory.
- IO_FIRST_PAGE, 12, page number of I/O channel 0.
- IO_CH, 4, number of I/O chip selects; IO_FIRST_PAGE+IO_CH must not exceed 2^PAGE_BITS.
- WAIT_BITS, 4, width of the wait counter.
- MEM_WAIT, 1, wait cycles for memory accesses.
- IO_WAIT, 0, wait cycles for I/O accesses; simif accesses always have 0 wait cycles.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- addr, input, MEM_ADDR_SIZE, bus address; must be held stable while req=1.
- req, input, 1, access request from the bus master.
- cs_mem, output, 1, memory select.
- cs_io, output, IO_CH, one-hot I/O channel selects.
- cs_simif, output, 1, simulator-interface select.
- ready, output, 1, access completes in any cycle where req=1 and ready=1.
- bus_err, output, 1, combinational pulse in the completing cycle of an unmapped access.
- err_flag, output, 1, sticky unmapped-access flag.
- err_addr, output, MEM_ADDR_SIZE, address of the first unmapped access since the last clear.
- err_cnt, output, 8, saturating count of unmapped accesses.
- err_clr, input, 1, clears err_flag and err_cnt.

Behaviour:
- Definitions:
  - in64 = (addr[MEM_ADDR_SIZE-1:16] == 0).
  - page = addr[15:16-PAGE_BITS].
  - simhit = in64 & (addr[15:0] == 16'hffff).
- Selects are combinational and gated by req, and are all forced to 0 while reset=0:
  - cs_simif = req & simhit.
  - cs_mem = req & in64 & (page < MEM_PAGES) & ~simhit.
  - cs_io[i] = req & in64 & (page == IO_FIRST_PAGE+i) & ~simhit.
  - simif takes priority: if simhit, every cs_io bit is 0, even when page 0xF is an I/O page.
- unmapped = req & none of the selects asserted.
- Wait count n: MEM_WAIT for memory, IO_WAIT for I/O, 0 for simif, 0 for unmapped.
- State machine (IDLE, WAIT), with register wcnt of WAIT_BITS:
  - IDLE, req=0: ready=0; stay in IDLE.
  - IDLE, req=1 and n=0: ready=1 combinationally in the same cycle; stay in IDLE. This gives back-to-back single-cycle accesses if req stays high.
  - IDLE, req=1 and n>0: ready=0; wcnt <= n-1; go to WAIT.
  - WAIT, req=1: ready = (wcnt==0).
    - If wcnt!=0, decrement wcnt.
    - If wcnt==0, go to IDLE.
    - Result: ready is asserted exactly n cycles after the request cycle.
  - WAIT, req=0: the access is aborted; ready=0; go to IDLE. Error state and counters are unaffected.
- Error capture, evaluated on an unmapped access completing in IDLE:
  - bus_err=1 and ready=1 in that same cycle.
  - At the clock edge:
    - err_flag <= 1.
    - err_addr <= addr if err_flag was 0; otherwise err_addr holds.
    - err_cnt increments, saturating at 255.
- err_clr:
  - err_clr=1 with no error that cycle: err_flag <= 0 and err_cnt <= 0; err_addr holds.
  - err_clr=1 in the same cycle as a new error: the error wins. err_flag=1, err_addr=addr, err_cnt=1.
- Reset (reset=0 at a clock edge):
  - State machine goes to IDLE; wcnt=0, err_flag=0, err_addr=0, err_cnt=0.
  - While reset=0: ready=0, bus_err=0, all selects 0.
  - Reset in the middle of a WAIT aborts the access with no ready.

Test Plan:
- Defaults, req=1, addr=0x0000_2000, held → cs_mem=1; ready=0 in cycle 0; ready=1 in cycle 1; all cs_io bits 0.
- req=1, addr=0x0000_D004 → cs_io=4'b0010 and ready=1 in the same cycle. Next, addr=0x0000_FFFF → cs_simif=1, cs_io=0, ready=1 the same cycle.
- req=1, addr=0x0001_0000 → bus_err=1, ready=1, all selects 0; next cycle err_flag=1, err_addr=0x0001_0000, err_cnt=1. Then addr=0x0000_5000 → err_cnt=2, err_addr unchanged.
- Errors: 300 back-to-back unmapped accesses → err_cnt=255. Then err_clr=1 together with an unmapped access to 0x0000_8000 → err_flag=1, err_cnt=1, err_addr=0x0000_8000.
- MEM_WAIT=3, memory access → ready only in cycle 3. Drop req in cycle 2, then re-request → a full 3-cycle wait again, with no early ready.
- Assert reset=0 during WAIT → selects and ready are 0 immediately; after the edge, wcnt=0, err_flag=0, err_cnt=0, err_addr=0.
